// File: rtl/height_disp_pkg.sv
// rtl/height_disp_pkg.sv - shared constants, converter state type and helpers for the height digit display
package height_disp_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam logic [5:0] COLOR_WHITE = 6'b111111;
  localparam logic [5:0] COLOR_BLACK = 6'b000000;

  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

  function automatic int max_decimal(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with saturation and valid/ready intake
module bin2bcd_seq
  import height_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VAL_W      = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    value_valid_i,
  input  logic [VAL_W-1:0]        value_i,
  output logic                    value_ready_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    done_o
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int MAX_VAL = max_decimal(NUM_DIGITS);
  localparam int CNT_W   = $clog2(VAL_W + 1);

  conv_state_t       state_q, state_d;
  logic [VAL_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q, bcd_adj;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (value_valid_i) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(VAL_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    value_ready_o = (state_q == IDLE);
    done_o        = (state_q == DONE);
  end

  // Add-3 correction happens before the shift so each nibble stays a valid decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && value_valid_i) begin
      bin_q <= (32'(value_i) > MAX_VAL) ? VAL_W'(MAX_VAL) : value_i;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (state_q == CONV) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      cnt_q          <= cnt_q + 1'b1;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/height_digit_renderer.sv
// rtl/height_digit_renderer.sv - frame-latched BCD height display driving the glyph ROM over a 2-stage pixel pipe
// Optional build macro LEADING_ZERO_BLANK_EN renders leading zero digits as white.
module height_digit_renderer
  import height_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VAL_W      = 10,
  parameter int ORIGIN_X   = 16,
  parameter int ORIGIN_Y   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             value_valid,
  input  logic [VAL_W-1:0] value,
  output logic             value_ready,
  input  logic             frame_start,
  input  logic             pix_en,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic [3:0]       rom_digit,
  output logic [4:0]       rom_col,
  output logic [4:0]       rom_row,
  input  logic [5:0]       rom_data,
  output logic [5:0]       pix_color,
  output logic             pix_valid
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + GLYPH_W * NUM_DIGITS);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + GLYPH_H);

  logic [BCD_W-1:0] conv_bcd, pending_bcd_q, disp_bcd_q;
  logic             conv_done, pending_flag_q;

  bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS), .VAL_W(VAL_W)) u_conv (
    .clk           (clk),
    .reset         (reset),
    .value_valid_i (value_valid),
    .value_i       (value),
    .value_ready_o (value_ready),
    .bcd_o         (conv_bcd),
    .done_o        (conv_done)
  );

  // A result finishing on a frame_start cycle sets the flag after the load, so it waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_bcd_q  <= '0;
      pending_flag_q <= 1'b0;
      disp_bcd_q     <= '0;
    end else begin
      if (frame_start && pending_flag_q) begin
        disp_bcd_q     <= pending_bcd_q;
        pending_flag_q <= 1'b0;
      end
      if (conv_done) begin
        pending_bcd_q  <= conv_bcd;
        pending_flag_q <= 1'b1;
      end
    end
  end

  logic [9:0] dx;
  logic       in_box_d, blank_d;
  logic [3:0] nib, digit_d, rom_digit_d;
  logic [4:0] rom_col_d, rom_row_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic       lead_zero;
`endif

  assign dx = pix_x - X_LO[9:0];

  always_comb begin
    in_box_d = pix_en && ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI) &&
               ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);
    digit_d  = '0;
    blank_d  = 1'b0;
    nib      = '0;
`ifdef LEADING_ZERO_BLANK_EN
    lead_zero = 1'b1;
`endif
    for (int p = 0; p < NUM_DIGITS; p++) begin
      nib = disp_bcd_q[4*(NUM_DIGITS-1-p) +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (nib != 4'd0) lead_zero = 1'b0;
`endif
      if (dx[9:3] == 7'(p)) begin
        digit_d = nib;
`ifdef LEADING_ZERO_BLANK_EN
        blank_d = lead_zero && (p != NUM_DIGITS - 1);
`endif
      end
    end
    rom_digit_d = in_box_d ? digit_d : 4'd0;
    rom_col_d   = in_box_d ? {2'b00, dx[2:0]} : 5'd0;
    rom_row_d   = in_box_d ? (pix_y[4:0] - Y_LO[4:0]) : 5'd0;
  end

  logic       in_box_q, blank_q, en_q, pix_valid_q;
  logic [3:0] rom_digit_q;
  logic [4:0] rom_col_q, rom_row_q;
  logic [5:0] pix_color_q, pix_color_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_digit_q <= '0;
      rom_col_q   <= '0;
      rom_row_q   <= '0;
      in_box_q    <= 1'b0;
      blank_q     <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      rom_digit_q <= rom_digit_d;
      rom_col_q   <= rom_col_d;
      rom_row_q   <= rom_row_d;
      in_box_q    <= in_box_d;
      blank_q     <= blank_d;
      en_q        <= pix_en;
    end
  end

  always_comb begin
    pix_color_d = COLOR_BLACK;
    if (en_q) pix_color_d = (in_box_q && !blank_q) ? rom_data : COLOR_WHITE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_color_q <= COLOR_BLACK;
      pix_valid_q <= 1'b0;
    end else begin
      pix_color_q <= pix_color_d;
      pix_valid_q <= en_q;
    end
  end

  assign rom_digit = rom_digit_q;
  assign rom_col   = rom_col_q;
  assign rom_row   = rom_row_q;
  assign pix_color = pix_color_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: doc/height_digit_renderer.md
# height_digit_renderer

Renders the measured height as a row of decimal digits on the video output. It accepts a binary height sample and converts it to BCD with a sequential double-dabble. It latches the result into the displayed value only at frame boundaries, so no frame ever shows a torn value. During active video it sequences the shared digit-glyph ROM bank per pixel: digit select, glyph column and glyph row. It sits between the sensor measurement path and the pixel colour mux of the display pipeline.

## Interface
- NUM_DIGITS, 3, digits displayed, most significant on the left
- VAL_W, 10, width of the binary height input
- ORIGIN_X, 16, screen x of the left edge of the digit box
- ORIGIN_Y, 16, screen y of the top edge of the digit box
- clk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-high
- value_valid  in  1  new height sample offered
- value  in  VAL_W  binary height, unsigned
- value_ready  out  1  converter idle; a sample is accepted when value_valid and value_ready are both high
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- pix_en  in  1  active-video qualifier for pix_x and pix_y
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- rom_digit  out  4  glyph select, 0–9
- rom_col  out  5  glyph column, 0–7
- rom_row  out  5  glyph row, 0–15
- rom_data  in  6  combinational colour returned by the glyph ROM bank
- pix_color  out  6  rendered pixel colour
- pix_valid  out  1  pix_color qualifier

## Operation
- **Converter FSM states:** IDLE, CONV, DONE.
  - value_ready is high only in IDLE.
  - On accept, move to CONV.
  - If value > 10^NUM_DIGITS−1, saturate the operand to 10^NUM_DIGITS−1 (999 for defaults).
- **CONV:** exactly VAL_W cycles of shift with add-3 correction on every nibble ≥ 5. Then move to DONE.
- **DONE:** one cycle.
  - Write the result to pending_bcd (4·NUM_DIGITS bits) and set pending_flag.
  - Return to IDLE.
- **Display register disp_bcd:** loaded from pending_bcd only on a cycle with frame_start high and pending_flag high. pending_flag clears in that same cycle.
- **DONE coincident with frame_start:** the new result is not taken in that cycle. It is applied at the next frame_start.
- **value_valid while not IDLE:** ignored, because value_ready is low. The sample is not queued.
- **Digit box:** ORIGIN_X ≤ pix_x < ORIGIN_X+8·NUM_DIGITS and ORIGIN_Y ≤ pix_y < ORIGIN_Y+16.
  - Digit position p = (pix_x−ORIGIN_X)>>3; p = 0 is the most significant digit.
  - rom_col = (pix_x−ORIGIN_X)&7.
  - rom_row = pix_y−ORIGIN_Y.
  - rom_digit = BCD nibble of disp_bcd for position p.
- **Outside the box:** rom_digit, rom_col and rom_row are driven to 0. The colour is white (6'b111111).
- **pix_en low:** pix_color is 6'b000000 and pix_valid is 0.
- **Reset values:**
  - State IDLE, so value_ready = 1 in the first cycle after reset.
  - disp_bcd = 0, so "000" is displayed.
  - pending_flag = 0.
  - rom_digit = 0, rom_col = 0, rom_row = 0.
  - pix_color = 0, pix_valid = 0.
- **Reset mid-conversion:** the conversion is abandoned with no pending update.

## Timing
- **Pixel path, 2-cycle latency:**
  - Cycle N: pix_x, pix_y and pix_en are sampled.
  - Cycle N+1: rom_digit, rom_col and rom_row are registered, along with in-box, blank and en flags.
  - Cycle N+2: pix_color and pix_valid are valid. pix_color is the registered rom_data, or white when outside the box or blanked.
- **Conversion:**
  - Accept at cycle T.
  - pending_flag is high from T+VAL_W+2.
  - value_ready is high again at T+VAL_W+2.
- **Display update:** at the first frame_start at or after T+VAL_W+2. It takes effect for every pixel sampled from the following cycle.
- Throughput is one pixel per clock, with no stalls.

## Configuration
- **LEADING_ZERO_BLANK_EN defined:** leading zero digits render white.
  - Blanking covers every zero nibble more significant than the first non-zero nibble.
  - Position NUM_DIGITS−1 is never blanked; a value of 0 shows "  0".
  - Blanking is decided at stage 1 from disp_bcd.
- **LEADING_ZERO_BLANK_EN undefined:** all digits render, so 7 shows "007".

## Structure
- **Package height_disp_pkg:**
  - GLYPH_W = 8, GLYPH_H = 16.
  - COLOR_WHITE = 6'b111111, COLOR_BLACK = 6'b000000.
  - Converter state enum conv_state_t {IDLE, CONV, DONE}.
- **Sub-module bin2bcd_seq:** owns the converter FSM, saturation and the valid/ready handshake. It outputs the BCD result with a one-cycle done pulse.
- The top level holds pending and display registers, box decode and the 2-stage pixel pipeline.

## Test plan
- **Reset and start-up:** reset, pix_en = 1, pix_x = 16, pix_y = 16 -> pix_color = rom_data for digit 0 at N+2; value_ready = 1 after reset.
- **Conversion and frame latch:** offer value = 173 and hold frame_start low -> digits stay "000". Pulse frame_start after T+12 -> rom_digit = 1, 7, 3 at pix_x = 16, 24, 32.
- **Saturation:** value = 1023 -> displayed 9, 9, 9.
- **Busy and coincidence:**
  - value_valid during CONV -> not accepted; the first value persists.
  - frame_start in the DONE cycle -> update deferred to the next frame_start.
- **Box edges:** pix_x = 15 and 40, and pix_y = 32 -> white, rom outputs 0. pix_x = 39, pix_y = 31 -> rom_col = 7, rom_row = 15.
- **Leading zeros:** value = 7 with LEADING_ZERO_BLANK_EN defined -> positions 0 and 1 white. Same value with the macro undefined -> "007".
